// File: rtl/regbank_dump_ctrl_if.sv
// Handshake bundle between the dump controller, the register-bank debug port
// and the UART transmitter.
`timescale 1ns/1ps
interface regbank_dump_ctrl_if #(
   parameter int BITS_SIZE = 32,
   parameter int BITS_REGS = 5,
   parameter int BITS_BYTE = 8
);
   logic                 i_start;
   logic                 i_abort;
   logic [BITS_SIZE-1:0] i_reg_data;
   logic                 i_tx_done;
   logic [BITS_REGS-1:0] o_addr_reg;
   logic                 o_tx_start;
   logic [BITS_BYTE-1:0] o_tx_data;
   logic                 o_busy;
   logic                 o_done;

   modport master (
      output i_start, i_abort, i_reg_data, i_tx_done,
      input  o_addr_reg, o_tx_start, o_tx_data, o_busy, o_done
   );

   modport slave (
      input  i_start, i_abort, i_reg_data, i_tx_done,
      output o_addr_reg, o_tx_start, o_tx_data, o_busy, o_done
   );
endinterface

// File: rtl/regbank_dump_ctrl.sv
// Walks the register bank from address 0 upward and streams every register
// to the UART, least-significant byte first, one byte per tx_done handshake.
`timescale 1ns/1ps
module regbank_dump_ctrl #(
   parameter int BITS_SIZE = 32,
   parameter int BITS_REGS = 5,
   parameter int REG_SIZE  = 32,
   parameter int BITS_BYTE = 8
) (
   input logic                i_clk,
   input logic                i_reset,
   regbank_dump_ctrl_if.slave bus
);
   localparam int NB = BITS_SIZE / BITS_BYTE;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0]        LAST_BYTE = CW'(NB - 1);
   localparam logic [BITS_REGS-1:0] LAST_REG  = BITS_REGS'(REG_SIZE - 1);

   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, NEXT, DONE} state_t;

   state_t               state;
   logic [BITS_REGS-1:0] addr;
   logic [CW-1:0]        cnt;
   logic [BITS_SIZE-1:0] sh;
   logic                 tx_start, busy, done;

   // Control outputs are registered alongside the state so they track it exactly.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state    <= IDLE;
         addr     <= '0;
         cnt      <= '0;
         sh       <= '0;
         tx_start <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b1;
         if (bus.i_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.i_start) begin
                     addr  <= '0;
                     state <= LOAD;
                  end else begin
                     busy <= 1'b0;
                  end
               end
               LOAD: begin
                  sh       <= bus.i_reg_data;
                  cnt      <= '0;
                  tx_start <= 1'b1;
                  state    <= SEND;
               end
               SEND: state <= WAIT;
               WAIT: begin
                  if (bus.i_tx_done) begin
                     if (cnt == LAST_BYTE) begin
                        state <= NEXT;
                     end else begin
                        cnt      <= cnt + 1'b1;
                        sh       <= sh >> BITS_BYTE;
                        tx_start <= 1'b1;
                        state    <= SEND;
                     end
                  end
               end
               NEXT: begin
                  if (addr == LAST_REG) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     addr  <= addr + 1'b1;
                     state <= LOAD;
                  end
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.o_addr_reg = addr;
   assign bus.o_tx_start = tx_start;
   assign bus.o_tx_data  = sh[BITS_BYTE-1:0];
   assign bus.o_busy     = busy;
   assign bus.o_done     = done;
endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Directed bench for regbank_dump_ctrl: full dumps, stray start/tx_done,
// long stall, abort and asynchronous reset mid-dump.
`timescale 1ns/1ps
module tb_regbank_dump_ctrl;
   localparam int BS = 32, BR = 5, RS = 32, BB = 8;
   localparam int NBYTES = RS * BS / BB;

   logic gclk   = 1'b0;
   logic grst_n = 1'b0;
   always #5 gclk = ~gclk;

   regbank_dump_ctrl_if #(.BITS_SIZE(BS), .BITS_REGS(BR), .BITS_BYTE(BB)) bus();
   assign bus.i_reg_data = 32'h11223300 + {27'd0, bus.o_addr_reg};

   regbank_dump_ctrl #(.BITS_SIZE(BS), .BITS_REGS(BR), .REG_SIZE(RS), .BITS_BYTE(BB)) dut (
      .i_clk   (gclk),
      .i_reset (grst_n),
      .bus     (bus)
   );

   int n_chk = 0, n_fail = 0;
   logic [7:0] q_data[$];
   logic [4:0] q_addr[$];
   int  done_cnt = 0, dly = 0;
   bit  resp_en = 1'b1, inj_send = 1'b0, kick = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: sample outputs at the falling edge, then drive the UART model,
   // which answers each byte with tx_done three cycles after tx_start.
   task automatic tick();
      @(negedge gclk);
      if (bus.o_tx_start) begin
         q_data.push_back(bus.o_tx_data);
         q_addr.push_back(bus.o_addr_reg);
      end
      if (bus.o_done) done_cnt++;
      bus.i_tx_done = 1'b0;
      if (dly > 0) begin
         dly--;
         if (dly == 0 && resp_en) bus.i_tx_done = 1'b1;
      end
      if (kick) begin
         bus.i_tx_done = 1'b1;
         kick = 1'b0;
      end
      if (bus.o_tx_start) begin
         dly = 3;
         if (inj_send) begin
            bus.i_tx_done = 1'b1;
            inj_send = 1'b0;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, {31'd0, bus.o_busy}, 32'd0);
      chk({tag, "_txs"},  {31'd0, bus.o_tx_start}, 32'd0);
      chk({tag, "_done"}, {31'd0, bus.o_done}, 32'd0);
      chk({tag, "_addr"}, {27'd0, bus.o_addr_reg}, 32'd0);
      chk({tag, "_data"}, {24'd0, bus.o_tx_data}, 32'd0);
   endtask

   task automatic start_dump();
      q_data.delete();
      q_addr.delete();
      done_cnt = 0;
      dly      = 0;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
   endtask

   // mode 0: plain, 1: stray start + tx_done in SEND at byte 50, 2: 1000-cycle stall
   task automatic run_dump(input int mode);
      int guard;
      bit did;
      logic [7:0] d0;
      logic [4:0] a0;
      int changes, extra;
      logic [7:0] eb;
      guard = 0;
      did   = 1'b0;
      start_dump();
      chk("load_busy", {31'd0, bus.o_busy}, 32'd1);
      chk("load_txs",  {31'd0, bus.o_tx_start}, 32'd0);
      tick();
      chk("first_txs",  {31'd0, bus.o_tx_start}, 32'd1);
      chk("first_addr", {27'd0, bus.o_addr_reg}, 32'd0);
      chk("first_data", {24'd0, bus.o_tx_data}, 32'h00);
      while (done_cnt == 0 && guard < 20000) begin
         tick();
         guard++;
         if (bus.i_start) bus.i_start = 1'b0;
         if (mode == 1 && !did && q_data.size() == 50) begin
            did = 1'b1;
            bus.i_start = 1'b1;
            inj_send = 1'b1;
         end
         if (mode == 2 && !did && q_data.size() == 10) begin
            did = 1'b1;
            resp_en = 1'b0;
            d0 = bus.o_tx_data;
            a0 = bus.o_addr_reg;
            changes = 0;
            extra = 0;
            repeat (1000) begin
               tick();
               if (bus.o_tx_data !== d0 || bus.o_addr_reg !== a0 || !bus.o_busy) changes++;
               if (bus.o_tx_start) extra++;
            end
            chk("stall_changes", changes, 0);
            chk("stall_txs", extra, 0);
            resp_en = 1'b1;
            kick = 1'b1;
         end
      end
      chk("done_seen", {31'd0, guard < 20000}, 32'd1);
      chk("done_busy", {31'd0, bus.o_busy}, 32'd1);
      chk("done_addr", {27'd0, bus.o_addr_reg}, RS - 1);
      tick();
      chk("busy_after_done", {31'd0, bus.o_busy}, 32'd0);
      chk("done_pulses", done_cnt, 1);
      chk("byte_count", q_data.size(), NBYTES);
      for (int i = 0; i < q_data.size() && i < NBYTES; i++) begin
         case (i % 4)
            0:       eb = 8'(i / 4);
            1:       eb = 8'h33;
            2:       eb = 8'h22;
            default: eb = 8'h11;
         endcase
         chk("byte", {24'd0, q_data[i]}, {24'd0, eb});
         chk("byte_addr", {27'd0, q_addr[i]}, i / 4);
      end
   endtask

   initial begin
      int guard;
      bus.i_start   = 1'b0;
      bus.i_abort   = 1'b0;
      bus.i_tx_done = 1'b0;
      repeat (3) tick();
      chk_zero("reset");
      grst_n = 1'b1;

      // Start on the first edge after reset release, then the stress variants.
      run_dump(0);
      repeat (3) tick();
      run_dump(1);
      repeat (3) tick();
      run_dump(2);
      repeat (3) tick();

      // Abort at address 7, byte 2.
      start_dump();
      guard = 0;
      while (q_data.size() < 31 && guard < 2000) begin
         tick();
         guard++;
      end
      chk("abort_reached", q_data.size(), 31);
      chk("abort_addr", {27'd0, bus.o_addr_reg}, 32'd7);
      chk("abort_data", {24'd0, bus.o_tx_data}, 32'h22);
      bus.i_abort = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      chk("abort_busy", {31'd0, bus.o_busy}, 32'd0);
      chk("abort_txs",  {31'd0, bus.o_tx_start}, 32'd0);
      repeat (10) tick();
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", {31'd0, bus.o_busy}, 32'd0);
      run_dump(0);

      // Abort and start together in IDLE: abort wins.
      bus.i_abort = 1'b1;
      bus.i_start = 1'b1;
      tick();
      bus.i_abort = 1'b0;
      bus.i_start = 1'b0;
      chk("abort_start_idle", {31'd0, bus.o_busy}, 32'd0);
      tick();
      chk("abort_start_txs", {31'd0, bus.o_tx_start}, 32'd0);

      // Asynchronous reset in the middle of a cycle at address 20.
      start_dump();
      guard = 0;
      while (bus.o_addr_reg != 5'd20 && guard < 2000) begin
         tick();
         guard++;
      end
      chk("arst_reached", {27'd0, bus.o_addr_reg}, 32'd20);
      #2 grst_n = 1'b0;
      #1 chk_zero("arst");
      repeat (3) tick();
      chk_zero("arst_hold");
      grst_n = 1'b1;
      run_dump(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/regbank_dump_ctrl.md
REGBANK_DUMP_CTRL -- requirements
Module: regbank_dump_ctrl

Interface
REQ-001 SHALL have parameter BITS_SIZE, default 32, register data width.
REQ-002 SHALL have parameter BITS_REGS, default 5, register address width.
REQ-003 SHALL have parameter REG_SIZE, default 32, number of registers dumped.
REQ-004 SHALL have parameter BITS_BYTE, default 8, UART byte width.
REQ-005 SHALL have port i_clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port i_reset  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 SHALL have port i_start  input  1  dump request, sampled only in IDLE.
REQ-008 SHALL have port i_abort  input  1  synchronous abort of an active dump.
REQ-009 SHALL have port i_reg_data  input  BITS_SIZE  register-bank debug read data for o_addr_reg (combinational read).
REQ-010 SHALL have port i_tx_done  input  1  UART transmitter one-cycle byte-complete pulse.
REQ-011 SHALL have port o_addr_reg  output  BITS_REGS  register-bank debug read address.
REQ-012 SHALL have port o_tx_start  output  1  one-cycle pulse launching one UART byte.
REQ-013 SHALL have port o_tx_data  output  BITS_BYTE  byte to transmit.
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse on dump completion.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, SEND, WAIT, NEXT, DONE; all outputs decoded from registered state/registers, no input-to-output combinational paths.
REQ-017 IDLE: on i_start=1, SHALL clear o_addr_reg to 0 and go to LOAD; otherwise stay.
REQ-018 LOAD: SHALL capture i_reg_data into a BITS_SIZE shift register, clear byte counter, go to SEND.
REQ-019 SEND: o_tx_start SHALL be 1 for exactly this one cycle; go to WAIT unconditionally.
REQ-020 o_tx_data SHALL equal the selected byte, least-significant byte first (byte n = data[8n+7:8n]), stable from SEND through WAIT exit.
REQ-021 WAIT: on i_tx_done=1, if byte counter = BITS_SIZE/BITS_BYTE-1 go to NEXT, else increment counter and go to SEND; otherwise stay (no timeout).
REQ-022 NEXT: if o_addr_reg = REG_SIZE-1 go to DONE, else increment o_addr_reg and go to LOAD.
REQ-023 DONE: o_done SHALL be 1 for this one cycle; go to IDLE; o_addr_reg holds REG_SIZE-1.
REQ-024 First o_tx_start SHALL occur in the second cycle after the edge sampling i_start (IDLE->LOAD->SEND).
REQ-025 A full dump SHALL issue exactly REG_SIZE*BITS_SIZE/BITS_BYTE o_tx_start pulses (128 at defaults), addresses 0..REG_SIZE-1 in ascending order, no wrap.
REQ-026 i_start while o_busy=1 SHALL be ignored (no restart, no queuing).
REQ-027 i_tx_done outside WAIT (including the SEND cycle) SHALL be ignored.
REQ-028 i_abort=1 in any non-IDLE state SHALL force IDLE next cycle, no o_done pulse, o_tx_start 0; an in-flight UART byte is not cancelled.
REQ-029 i_abort and i_start both 1 in IDLE: i_abort SHALL win, remain IDLE.
REQ-030 o_addr_reg SHALL change only in IDLE (clear on start) and NEXT, so i_reg_data is settled at LOAD.

Reset
REQ-031 i_reset=0 SHALL immediately, asynchronously force IDLE, o_addr_reg=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, counter and shift register 0.
REQ-032 Reset mid-dump SHALL abandon the dump; after release the block SHALL wait in IDLE for a new i_start.
REQ-033 First i_start SHALL be honoured on the first rising edge after i_reset returns to 1.

Verification
REQ-034 Bank reg k = 0x11223300+k, i_tx_done 3 cycles after each o_tx_start, pulse i_start -> 128 bytes 0x00,0x33,0x22,0x11,0x01,0x33,... ending 0x1F,0x33,0x22,0x11; single o_done; o_busy falls with DONE exit.
REQ-035 Pulse i_start, check cycle count -> o_tx_start high exactly 2 cycles after sampling edge, o_addr_reg=0, o_tx_data=0x00.
REQ-036 Pulse i_start at byte 50 and i_tx_done during SEND cycle -> no restart, no skipped byte, sequence identical to REQ-034.
REQ-037 Hold i_tx_done=0 for 1000 cycles in WAIT -> state, o_tx_data, o_addr_reg unchanged, no extra o_tx_start.
REQ-038 Assert i_abort at address 7 byte 2 -> IDLE next cycle, no o_done; new i_start restarts at address 0.
REQ-039 Drive i_reset=0 asynchronously mid-cycle at address 20 -> all outputs 0 before next edge; after release, i_start yields full 128-byte dump.
